// File: rtl/iecdrv_pkg.sv
// Shared types and constants for the drive-side GCR track reader.
// Bit timing is expressed in 16 MHz-equivalent ce ticks.
package iecdrv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } trk_state_t;

    localparam int SYNC_BITS        = 10;
    localparam int BYTE_READY_TICKS = 8;
    localparam int PERIOD_W         = 7;

    // Bit-cell length in ce ticks: 64/60/56/52 for zones 0..3
    function automatic logic [PERIOD_W-1:0] zone_period(input logic [1:0] speed);
        return {5'd16 - {3'd0, speed}, 2'b00};
    endfunction

endpackage

// File: rtl/iecdrv_gcr_decoder.sv
// Models the drive read electronics: SYNC detector, bit counter, byte latch
// and the BYTE READY strobe.
module iecdrv_gcr_decoder
    import iecdrv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_ce,
    input  logic       i_bit_tick,
    input  logic       i_bit,
    input  logic       i_soe,
    output logic [7:0] o_dout,
    output logic       o_sync,
    output logic       o_byte_n
);

    logic [SYNC_BITS-2:0] r_rx;
    logic                 r_sync;
    logic [2:0]           r_cnt;
    logic [3:0]           r_bn_cnt;
    logic [7:0]           r_dout;

    logic [SYNC_BITS-1:0] w_win;
    logic                 w_all_ones;
    logic                 w_done;

    assign w_win      = {r_rx, i_bit};
    assign w_all_ones = &w_win;
    assign w_done     = i_bit_tick && !i_clr && !w_all_ones && !r_sync && (r_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_rx   <= '0;
            r_sync <= 1'b0;
            r_cnt  <= 3'd0;
        end else if (i_bit_tick) begin
            r_rx <= w_win[SYNC_BITS-2:0];
            if (w_all_ones) begin
                r_sync <= 1'b1;
                r_cnt  <= 3'd0;
            end else if (r_sync) begin
                // first non-sync bit is bit 7 of the first byte
                r_sync <= 1'b0;
                r_cnt  <= 3'd1;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= 8'h00;
        end else if (w_done) begin
            r_dout <= w_win[7:0];
        end
    end

    // soe is only looked at when a byte completes; a new byte restarts the window
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_bn_cnt <= 4'd0;
        end else if (w_done && i_soe) begin
            r_bn_cnt <= 4'(BYTE_READY_TICKS);
        end else if (i_ce && (r_bn_cnt != 4'd0)) begin
            r_bn_cnt <= r_bn_cnt - 4'd1;
        end
    end

    assign o_dout   = r_dout;
    assign o_sync   = r_sync;
    assign o_byte_n = (r_bn_cnt == 4'd0);

endmodule

// File: rtl/iecdrv_track_reader.sv
// Read side of the GCR track buffer: fetches track bytes, serializes them at
// the zone bit rate and feeds the GCR decoder.
module iecdrv_track_reader
    import iecdrv_pkg::*;
#(
    parameter int ADDRWIDTH = 13
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 mtr,
    input  logic                 busy,
    input  logic [1:0]           speed,
    input  logic                 soe,
    input  logic [ADDRWIDTH-1:0] track_len,
    output logic [ADDRWIDTH-1:0] mem_addr,
    input  logic [7:0]           mem_q,
    output logic [7:0]           dout,
    output logic                 sync_n,
    output logic                 byte_n
);

    trk_state_t            r_state;
    logic [1:0]            r_prime_cnt;
    logic [ADDRWIDTH-1:0]  r_pos;
    logic [ADDRWIDTH-1:0]  r_addr;
    logic [PERIOD_W-1:0]   r_per;
    logic [PERIOD_W-1:0]   r_per_tc;
    logic [3:0]            r_bits_left;
    logic [2:0]            r_fetch;
    logic [7:0]            r_sh;
    logic [7:0]            r_nxt;

    logic                  w_halt;
    logic [ADDRWIDTH-1:0]  w_pos_inc;
    logic [ADDRWIDTH-1:0]  w_pos_next;
    logic                  w_run_en;
    logic                  w_tick;
    logic                  w_load;
    logic                  w_reload;
    logic                  w_sync;

    assign w_halt     = busy || (track_len == '0);
    assign w_pos_inc  = r_pos + {{(ADDRWIDTH-1){1'b0}}, 1'b1};
    assign w_pos_next = (w_pos_inc == track_len) ? '0 : w_pos_inc;
    assign w_run_en   = (r_state == RUN) && mtr && ce && !w_halt;
    assign w_tick     = w_run_en && (r_per == r_per_tc);
    assign w_load     = (r_state == PRIME) && (r_prime_cnt == 2'd2) && !w_halt;
    assign w_reload   = w_tick && (r_bits_left == 4'd1);

    always_ff @(posedge clk) begin
        if (reset || w_halt) begin
            r_state     <= IDLE;
            r_prime_cnt <= 2'd0;
            r_pos       <= '0;
            r_addr      <= '0;
            r_per       <= '0;
            r_per_tc    <= '0;
            r_bits_left <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mtr) begin
                        r_state     <= PRIME;
                        r_prime_cnt <= 2'd0;
                        r_addr      <= r_pos;
                    end
                end
                PRIME: begin
                    if (r_prime_cnt == 2'd2) begin
                        r_state     <= RUN;
                        r_per       <= '0;
                        r_per_tc    <= zone_period(speed) - 7'd1;
                        r_bits_left <= 4'd8;
                        r_pos       <= w_pos_next;
                        r_addr      <= w_pos_next;
                    end else begin
                        r_prime_cnt <= r_prime_cnt + 2'd1;
                    end
                end
                RUN: begin
                    // motor off simply stops the bit clock; everything holds
                    if (w_tick) begin
                        r_per    <= '0;
                        r_per_tc <= zone_period(speed) - 7'd1;
                        if (w_reload) begin
                            r_bits_left <= 4'd8;
                            r_pos       <= w_pos_next;
                            r_addr      <= w_pos_next;
                        end else begin
                            r_bits_left <= r_bits_left - 4'd1;
                        end
                    end else if (w_run_en) begin
                        r_per <= r_per + 7'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // nxt is captured three clk after its address is issued, matching PRIME
    always_ff @(posedge clk) begin
        if (reset || w_halt) begin
            r_fetch <= 3'd0;
        end else if (w_load || w_reload) begin
            r_fetch <= 3'b001;
        end else begin
            r_fetch <= {r_fetch[1:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (r_fetch[2]) begin
            r_nxt <= mem_q;
        end
        if (w_load) begin
            r_sh <= mem_q;
        end else if (w_reload) begin
            r_sh <= r_nxt;
        end else if (w_tick) begin
            r_sh <= {r_sh[6:0], 1'b0};
        end
    end

    iecdrv_gcr_decoder u_dec (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_halt),
        .i_ce       (ce),
        .i_bit_tick (w_tick),
        .i_bit      (r_sh[7]),
        .i_soe      (soe),
        .o_dout     (dout),
        .o_sync     (w_sync),
        .o_byte_n   (byte_n)
    );

    assign mem_addr = r_addr;
    assign sync_n   = ~w_sync;

endmodule
